alu_md_unit: RTL and testbench

Parametrised execute unit that succeeds the combinational ALU-control decoder. It decodes the same control inputs as before and executes base integer operations in one registered cycle. It adds RV M-extension multiply/divide as an iterative radix-2 engine behind a valid/ready handshake. It sits in the execute stage between the register-read outputs and the writeback mux.

---
 rtl/alu_md_unit.sv | 217 +++++++++++++++++++++
 tb/tb_alu_md_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage ALU with an iterative M-extension engine.
// Base ops complete in one registered cycle; MUL/DIV take XLEN+1 cycles.
module alu_md_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            Branch,
    input  logic            ALUAdd,
    input  logic            ALUOp,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_illegal,
    output logic            zero
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

    function automatic op_e base_op(input logic [2:0] f3, input logic arith);
        op_e o;
        case (f3)
            3'b000:  o = OP_ADD;
            3'b001:  o = OP_SLL;
            3'b010:  o = OP_SLT;
            3'b011:  o = OP_SLTU;
            3'b100:  o = OP_XOR;
            3'b101:  o = arith ? OP_SRA : OP_SRL;
            3'b110:  o = OP_OR;
            default: o = OP_AND;
        endcase
        return o;
    endfunction

    state_e state, state_nx;
    op_e op, mop;
    logic is_m, is_div, m_is_div, accept;
    logic sgn_a, sgn_b, neg_a, neg_b, b_zero;
    logic [XLEN-1:0] mag_a, mag_b, a_raw, x, base_res, fix_res;
    logic [XLEN-1:0] quo, rem;
    logic [2*XLEN-1:0] acc, mc, prod;
    logic [XLEN:0] rs, diff;
    logic [SW-1:0] shamt, count;

    // Decode the control flags into a single operation, in priority order
    always_comb begin
        op = OP_ILL;
        if (ALUAdd) op = OP_ADD;
        else if (Branch) op = OP_SUB;
        else if (ALUOp) op = base_op(funct3, funct7[5]);
        else if (funct7 == 7'b0000000) op = base_op(funct3, 1'b0);
        else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000) op = OP_SUB;
            else if (funct3 == 3'b101) op = OP_SRA;
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
            case (funct3)
                3'b000:  op = OP_MUL;
                3'b001:  op = OP_MULH;
                3'b010:  op = OP_MULHSU;
                3'b011:  op = OP_MULHU;
                3'b100:  op = OP_DIV;
                3'b101:  op = OP_DIVU;
                3'b110:  op = OP_REM;
                default: op = OP_REMU;
            endcase
        end
    end

    assign is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign is_m   = is_div || (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
    assign sgn_a  = op_a[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sgn_b  = op_b[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    assign mag_a  = sgn_a ? -op_a : op_a;
    assign mag_b  = sgn_b ? -op_b : op_b;
    assign shamt  = op_b[SW-1:0];
    assign accept = in_valid && in_ready;

    // Single-cycle base operations
    always_comb begin
        base_res = '0;
        case (op)
            OP_ADD:  base_res = op_a + op_b;
            OP_SUB:  base_res = op_a - op_b;
            OP_SLL:  base_res = op_a << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  base_res = op_a ^ op_b;
            OP_SRL:  base_res = op_a >> shamt;
            OP_SRA:  base_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   base_res = op_a | op_b;
            OP_AND:  base_res = op_a & op_b;
            default: base_res = '0;
        endcase
    end

    assign m_is_div = mop inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign rs       = {acc[XLEN-1:0], x[XLEN-1]};
    assign diff     = rs - {1'b0, mc[XLEN-1:0]};

    // Iterative engine: shift-add multiply or restoring divide on magnitudes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mop    <= OP_ADD;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            acc    <= '0;
            mc     <= '0;
            x      <= '0;
            count  <= '0;
        end else if (accept && is_m) begin
            mop    <= op;
            neg_a  <= sgn_a;
            neg_b  <= sgn_b;
            b_zero <= (op_b == '0);
            a_raw  <= op_a;
            acc    <= '0;
            count  <= '0;
            if (is_div) begin
                x  <= mag_a;
                mc <= {{XLEN{1'b0}}, mag_b};
            end else begin
                x  <= mag_b;
                mc <= {{XLEN{1'b0}}, mag_a};
            end
        end else if (state == S_ITER) begin
            count <= count + SW'(1);
            if (m_is_div) begin
                if (!diff[XLEN]) begin
                    acc <= {{XLEN{1'b0}}, diff[XLEN-1:0]};
                    x   <= {x[XLEN-2:0], 1'b1};
                end else begin
                    acc <= {{(XLEN-1){1'b0}}, rs};
                    x   <= {x[XLEN-2:0], 1'b0};
                end
            end else begin
                if (x[0]) acc <= acc + mc;
                mc <= mc << 1;
                x  <= x >> 1;
            end
        end
    end

    // Sign correction and divide special cases applied in FIX
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = b_zero ? '1 : ((neg_a ^ neg_b) ? -x : x);
        rem  = b_zero ? a_raw : (neg_a ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        case (mop)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo;
            OP_REM, OP_REMU:              fix_res = rem;
            default:                      fix_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept && is_m) state_nx = S_ITER;
            S_ITER: if (count == SW'(XLEN-1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake output: accept only when idle and the output slot frees up
    always_comb begin
        in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    end

    // Output register: holds until consumed, new load wins over drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result      <= '0;
            out_illegal <= 1'b0;
            zero        <= 1'b1;
        end else if (accept && !is_m) begin
            out_valid   <= 1'b1;
            result      <= base_res;
            out_illegal <= (op == OP_ILL);
            zero        <= (base_res == '0);
        end else if (state == S_FIX) begin
            out_valid   <= 1'b1;
            result      <= fix_res;
            out_illegal <= 1'b0;
            zero        <= (fix_res == '0);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: directed checks of base ops, M-extension engine,
// handshake back-pressure and reset abort.
module tb_alu_md_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic Branch = 1'b0, ALUAdd = 1'b0, ALUOp = 1'b0;
    logic [6:0] funct7 = '0;
    logic [2:0] funct3 = '0;
    logic [XLEN-1:0] op_a = '0, op_b = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic out_illegal;
    logic zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_md_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Branch(Branch), .ALUAdd(ALUAdd), .ALUOp(ALUOp),
        .funct7(funct7), .funct3(funct3),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_illegal(out_illegal), .zero(zero)
    );

    task automatic drive(input logic br, input logic ad, input logic aop,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        Branch = br; ALUAdd = ad; ALUOp = aop;
        funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic br, input logic ad, input logic aop,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        drive(br, ad, aop, f7, f3, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (result !== 32'h0) begin
            errors++; $display("FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if (out_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal got=%0b exp=0", out_illegal);
        end
        checks++;
        if (zero !== 1'b1) begin
            errors++; $display("FAIL reset_zero got=%0b exp=1", zero);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_shift;
        issue(0, 0, 1, 7'b0100000, 3'b101, 32'h80000000, 32'd4);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hF8000000) begin
            errors++;
            $display("FAIL imm_sra got=%h v=%0b exp=f8000000", result, out_valid);
        end
        issue(0, 0, 1, 7'b0000000, 3'b101, 32'h80000000, 32'd4);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h08000000) begin
            errors++;
            $display("FAIL imm_srl got=%h v=%0b exp=08000000", result, out_valid);
        end
    endtask

    task automatic test_base;
        logic        ads [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        aps [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [6:0]  f7s [12] = '{7'h7f, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20,
                                  7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
        logic [2:0]  f3s [12] = '{3'd3, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0,
                                  3'd1, 3'd4, 3'd6, 3'd7, 3'd5, 3'd5};
        logic [31:0] as  [12] = '{32'd10, 32'd9, 32'd3, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd5, 32'd1, 32'h0000F0F0,
                                  32'h0000F000, 32'h0000FF00, 32'h80000000,
                                  32'h80000000};
        logic [31:0] bs  [12] = '{32'd20, 32'd1, 32'd4, 32'd1, 32'd1, 32'd7,
                                  32'd33, 32'h00000FF0, 32'h0000000F,
                                  32'h00000FF0, 32'd4, 32'd4};
        logic [31:0] ex  [12] = '{32'd30, 32'd10, 32'd7, 32'd1, 32'd0,
                                  32'hFFFFFFFE, 32'd2, 32'h0000FF00,
                                  32'h0000F00F, 32'h00000F00, 32'h08000000,
                                  32'hF8000000};
        for (int i = 0; i < 12; i++) begin
            issue(0, ads[i], aps[i], f7s[i], f3s[i], as[i], bs[i]);
            checks++;
            if (result !== ex[i] || zero !== (ex[i] == 0) || out_illegal !== 1'b0) begin
                errors++;
                $display("FAIL base_%0d got=%h z=%0b il=%0b exp=%h",
                         i, result, zero, out_illegal, ex[i]);
            end
        end
    endtask

    task automatic test_branch_illegal;
        issue(1, 0, 0, 7'h00, 3'd0, 32'd5, 32'd5);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL branch_eq got=%h z=%0b exp=0 z=1", result, zero);
        end
        issue(1, 0, 0, 7'h00, 3'd0, 32'd5, 32'd3);
        checks++;
        if (result !== 32'd2 || zero !== 1'b0) begin
            errors++; $display("FAIL branch_ne got=%h z=%0b exp=2 z=0", result, zero);
        end
        issue(0, 0, 0, 7'b0000010, 3'd0, 32'd5, 32'd5);
        checks++;
        if (out_illegal !== 1'b1 || result !== 32'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_f7 got=%h il=%0b exp=0 il=1", result, out_illegal);
        end
        issue(0, 0, 0, 7'b0100000, 3'd1, 32'd5, 32'd5);
        checks++;
        if (out_illegal !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL illegal_sub_f3 got=%h il=%0b exp=0 il=1", result, out_illegal);
        end
        issue(0, 1, 0, 7'h00, 3'd0, 32'd1, 32'd1);
        checks++;
        if (out_illegal !== 1'b0 || result !== 32'd2) begin
            errors++;
            $display("FAIL illegal_clear got=%h il=%0b exp=2 il=0", result, out_illegal);
        end
    endtask

    task automatic test_mul;
        logic [2:0]  f3s [6] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd1};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd7, 32'h80000000};
        logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd2, 32'd6, 32'h80000000};
        logic [31:0] ex  [6] = '{32'd1, 32'hFFFFFFFE, 32'd0,
                                 32'hFFFFFFFF, 32'd42, 32'h40000000};
        int n;
        for (int i = 0; i < 6; i++) begin
            issue(0, 0, 0, 7'b0000001, f3s[i], as[i], bs[i]);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_%0d rdy=%0b v=%0b exp 0 0", i, in_ready, out_valid);
            end
            op_a = 32'h12345678;
            op_b = 32'h9ABCDEF0;
            wait_done(n);
            checks++;
            if (n != XLEN + 1) begin
                errors++; $display("FAIL mul_latency_%0d got=%0d exp=%0d", i, n, XLEN + 1);
            end
            checks++;
            if (result !== ex[i] || out_illegal !== 1'b0) begin
                errors++; $display("FAIL mul_%0d got=%h exp=%h", i, result, ex[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3s [10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4,
                                  3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [10] = '{32'h80000000, 32'h80000000, 32'd7, 32'd7,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                                  32'd2, 32'd2, 32'd0, 32'd0, 32'd7, 32'd7};
        logic [31:0] ex  [10] = '{32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd7,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'd14, 32'd2};
        int n;
        for (int i = 0; i < 10; i++) begin
            issue(0, 0, 0, 7'b0000001, f3s[i], as[i], bs[i]);
            wait_done(n);
            checks++;
            if (n != XLEN + 1 || result !== ex[i] || zero !== (ex[i] == 0)) begin
                errors++;
                $display("FAIL div_%0d got=%h n=%0d exp=%h n=%0d",
                         i, result, n, ex[i], XLEN + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        drive(0, 1, 0, 7'h00, 3'd0, 32'd1, 32'd2);
        @(posedge clk); #1;
        drive(0, 1, 0, 7'h00, 3'd0, 32'd10, 32'd20);
        checks++;
        if (result !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_0 got=%h rdy=%0b exp=3 rdy=1", result, in_ready);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 7'h20, 3'd0, 32'd100, 32'd1);
        checks++;
        if (result !== 32'd30) begin
            errors++; $display("FAIL b2b_1 got=%h exp=1e", result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd99) begin
            errors++; $display("FAIL b2b_2 got=%h exp=63", result);
        end
    endtask

    task automatic test_backpressure;
        int bad_res = 0;
        int bad_rdy = 0;
        issue(0, 1, 0, 7'h00, 3'd0, 32'd1, 32'd1);
        out_ready = 1'b0;
        drive(0, 1, 0, 7'h00, 3'd0, 32'd10, 32'd20);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== 32'd2 || out_valid !== 1'b1) bad_res++;
            if (in_ready !== 1'b0) bad_rdy++;
        end
        checks++;
        if (bad_res != 0) begin
            errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (res=%h)", bad_res, result);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++; $display("FAIL bp_in_ready got=%0d bad cycles exp=0", bad_rdy);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_rdy got=%0b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd30 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_drain_accept got=%h v=%0b exp=1e v=1", result, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        int ghost = 0;
        issue(0, 0, 0, 7'b0000001, 3'd0, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
        end
        issue(0, 1, 0, 7'h00, 3'd0, 32'd3, 32'd4);
        checks++;
        if (result !== 32'd7 || out_valid !== 1'b1) begin
            errors++; $display("FAIL post_rst_add got=%h v=%0b exp=7 v=1", result, out_valid);
        end
        for (int i = 0; i < XLEN + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ghost++;
        end
        checks++;
        if (ghost != 0) begin
            errors++; $display("FAIL post_rst_ghost got=%0d valid cycles exp=0", ghost);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_shift();
        test_base();
        test_branch_illegal();
        test_mul();
        test_div();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
